// File: rtl/mem_arb_if.sv
// Request/response bundle between the fetch stage, the load/store stage, the
// memory port and the arbiter. slave is the arbiter's view; master is everyone else's.
interface mem_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned SW = DW / 8;

    logic          if_req_val;
    logic          if_req_rdy;
    logic [AW-1:0] if_req_addr;
    logic          if_flush;
    logic          if_rsp_val;
    logic [DW-1:0] if_rsp_data;

    logic          ls_req_val;
    logic          ls_req_rdy;
    logic [AW-1:0] ls_req_addr;
    logic          ls_req_wen;
    logic [DW-1:0] ls_req_wdata;
    logic [SW-1:0] ls_req_wstrb;
    logic          ls_rsp_val;
    logic [DW-1:0] ls_rsp_data;

    logic          mem_req_val;
    logic          mem_req_rdy;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [DW-1:0] mem_req_wdata;
    logic [SW-1:0] mem_req_wstrb;
    logic          mem_rsp_val;
    logic [DW-1:0] mem_rsp_data;

    modport slave (
        input  if_req_val, if_req_addr, if_flush,
        output if_req_rdy, if_rsp_val, if_rsp_data,
        input  ls_req_val, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wstrb,
        output ls_req_rdy, ls_rsp_val, ls_rsp_data,
        output mem_req_val, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_rdy, mem_rsp_val, mem_rsp_data
    );

    modport master (
        output if_req_val, if_req_addr, if_flush,
        input  if_req_rdy, if_rsp_val, if_rsp_data,
        output ls_req_val, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wstrb,
        input  ls_req_rdy, ls_rsp_val, ls_rsp_data,
        input  mem_req_val, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_rdy, mem_rsp_val, mem_rsp_data
    );
endinterface

// File: rtl/mem_arb.sv
// Single-port memory arbiter: one outstanding transaction, load/store priority
// with a fetch starvation guard, and dropping of fetch responses made stale by a flush.
module mem_arb #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);
    localparam int unsigned CW = 4;
    localparam int unsigned SW = DW / 8;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD_IF = 3'd1,
        HOLD_LS = 3'd2,
        WAIT_IF = 3'd3,
        WAIT_LS = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          drop, drop_nxt;
    logic          if_wins, own_if, own_ls, issue, accept;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic [SW-1:0] wstrb_mux;

    // State, starvation counter and stale-fetch flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            drop       <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            drop       <= drop_nxt;
        end
    end

    // Arbitration, grant ownership and next-state
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        drop_nxt   = drop;
        own_if     = 1'b0;
        own_ls     = 1'b0;
        issue      = 1'b0;
        if_wins    = bus.if_req_val && (!bus.ls_req_val || (starve_cnt == STARVE_LIM));

        unique case (state)
            IDLE: begin
                if (bus.if_req_val || bus.ls_req_val) begin
                    issue  = 1'b1;
                    own_if = if_wins;
                    own_ls = !if_wins;
                end
            end
            HOLD_IF: begin
                issue  = 1'b1;
                own_if = 1'b1;
            end
            HOLD_LS: begin
                issue  = 1'b1;
                own_ls = 1'b1;
            end
            default: ;
        endcase

        accept = issue && bus.mem_req_rdy;

        unique case (state)
            IDLE: begin
                if (issue) begin
                    if (own_if) state_nxt = accept ? WAIT_IF : HOLD_IF;
                    else        state_nxt = accept ? WAIT_LS : HOLD_LS;
                end
            end
            HOLD_IF: if (accept) state_nxt = WAIT_IF;
            HOLD_LS: if (accept) state_nxt = WAIT_LS;
            WAIT_IF, WAIT_LS: if (bus.mem_rsp_val) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Only load/store wins taken from IDLE against a waiting fetch count
        if (accept && own_if) begin
            starve_nxt = '0;
        end else if (accept && own_ls && (state == IDLE) && bus.if_req_val
                     && (starve_cnt < STARVE_LIM)) begin
            starve_nxt = starve_cnt + CW'(1);
        end

        // The response consumes the flag; a flush while a fetch is owned arms it
        if ((state == WAIT_IF) && bus.mem_rsp_val) begin
            drop_nxt = 1'b0;
        end else if (bus.if_flush && ((state == HOLD_IF) || (state == WAIT_IF)
                                      || ((state == IDLE) && accept && own_if))) begin
            drop_nxt = 1'b1;
        end
    end

    // Memory request fields follow the owner; a fetch never writes
    always_comb begin
        addr_mux  = own_if ? bus.if_req_addr : bus.ls_req_addr;
        wdata_mux = own_ls ? bus.ls_req_wdata : '0;
        wstrb_mux = own_ls ? bus.ls_req_wstrb : '0;
    end

    assign bus.mem_req_val   = !rst && issue;
    assign bus.mem_req_addr  = addr_mux;
    assign bus.mem_req_wen   = own_ls && bus.ls_req_wen;
    assign bus.mem_req_wdata = wdata_mux;
    assign bus.mem_req_wstrb = wstrb_mux;

    assign bus.if_req_rdy = !rst && own_if && bus.mem_req_rdy;
    assign bus.ls_req_rdy = !rst && own_ls && bus.mem_req_rdy;

    assign bus.if_rsp_val  = !rst && (state == WAIT_IF) && bus.mem_rsp_val
                             && !drop && !bus.if_flush;
    assign bus.if_rsp_data = bus.mem_rsp_data;
    assign bus.ls_rsp_val  = !rst && (state == WAIT_LS) && bus.mem_rsp_val;
    assign bus.ls_rsp_data = bus.mem_rsp_data;
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
Single-port memory arbiter shared by the instruction-fetch stage and the load/store stage. Grants the memory port to one requester at a time and allows one outstanding transaction. Routes each response back to its owner. Load/store has priority, with a starvation guard for fetch. A fetch flush on redirect discards a stale fetch response.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, number of consecutive load/store wins while fetch waits before fetch is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req_val  in  1  fetch request valid
if_req_rdy  out  1  fetch request accepted this cycle
if_req_addr  in  AW  fetch address
if_flush  in  1  pipeline redirect; discard any pending fetch response
if_rsp_val  out  1  fetch response valid, one-cycle pulse
if_rsp_data  out  DW  fetch instruction word
ls_req_val  in  1  load/store request valid
ls_req_rdy  out  1  load/store request accepted this cycle
ls_req_addr  in  AW  load/store address
ls_req_wen  in  1  1 = store, 0 = load
ls_req_wdata  in  DW  store data
ls_req_wstrb  in  DW/8  store byte strobes
ls_rsp_val  out  1  load/store response valid, one-cycle pulse; data is don't-care for stores
ls_rsp_data  out  DW  load data
mem_req_val  out  1  memory request valid
mem_req_rdy  in  1  memory accepts request
mem_req_addr  out  AW  memory address
mem_req_wen  out  1  memory write enable
mem_req_wdata  out  DW  memory write data
mem_req_wstrb  out  DW/8  memory byte strobes; all zero for fetch
mem_rsp_val  in  1  memory response valid; earliest one cycle after acceptance
mem_rsp_data  in  DW  memory response data

Behaviour:
- States: IDLE, HOLD_IF, HOLD_LS, WAIT_IF, WAIT_LS. Reset value is IDLE.
- Reset (async, any state): state=IDLE, starve_cnt=0, drop=0.
  - All *_val and *_rdy outputs are 0 while rst is high.
  - A memory response arriving after reset is ignored.
- IDLE arbitration (combinational):
  - Only ls valid: LS wins. Only if valid: IF wins.
  - Both valid: IF wins if starve_cnt==STARVE_MAX, otherwise LS wins.
- Driving the memory port:
  - mem_req_val=1 in IDLE when any request is valid, and always in HOLD_x.
  - mem_req_* carry the winner/owner's fields.
  - For fetch: wen=0, wstrb=0, wdata=0.
- Acceptance: the winner/owner's *_req_rdy equals mem_req_rdy. The loser's rdy is 0.
  - Latency is zero: a request is accepted in the same cycle as valid when memory is ready.
- Transitions out of IDLE: to WAIT_x on accept; to HOLD_x if mem_req_rdy=0.
- HOLD_x:
  - The grant is locked; the other requester cannot preempt.
  - The requester must hold valid and its fields stable (protocol rule; not checked).
  - Goes to WAIT_x on mem_req_rdy.
- WAIT_x:
  - No new request is issued (mem_req_val=0).
  - On mem_rsp_val: pulse x_rsp_val with mem_rsp_data for one cycle, then go to IDLE.
  - A new request can be accepted the cycle after the response.
- starve_cnt (4-bit, saturates at STARVE_MAX):
  - +1 when LS is accepted in IDLE while if_req_val=1.
  - Cleared when IF is accepted.
  - Otherwise held.
- Flush:
  - if_flush while in HOLD_IF/WAIT_IF, or in the IDLE cycle that accepts an IF request, sets drop=1.
  - if_flush in the same cycle as the IF response suppresses if_rsp_val.
  - When the response arrives with drop=1, if_rsp_val stays 0 and drop clears.
  - if_flush with no fetch owned: no effect.
  - The flush never cancels the memory transaction itself.
- mem_rsp_val in IDLE/HOLD_x is ignored (protocol violation).
- Responses return in order trivially, because only one transaction is ever outstanding.

Test Plan:
- Reset: assert rst mid-WAIT_LS, deassert, then pulse mem_rsp_val.
  - Required: ls_rsp_val stays 0, state is IDLE, all rdy outputs are 0 during rst.
- Single fetch: if_req_addr=0x80000000, mem_req_rdy=1, mem_rsp_val 2 cycles later with data 0x00000013.
  - Required: if_req_rdy=1 in cycle 0, if_rsp_val=1 with 0x00000013 exactly once.
  - Required: mem_req_wstrb=0 throughout.
- Contention and starvation: both valid continuously, STARVE_MAX=4, 1-cycle memory.
  - Required grant order: LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Hold lock: LS request with mem_req_rdy=0 for 3 cycles while if_req_val rises in cycle 1.
  - Required: mem_req_addr stays the LS address, if_req_rdy=0 until the LS completes.
- Store: wen=1, wdata=0xDEADBEEF, wstrb=0xC.
  - Required: mem_req_* mirror these values, ls_rsp_val pulses once.
- Flush:
  - Case 1: if_flush one cycle after IF acceptance, response arrives 3 cycles later. Required: if_rsp_val=0.
  - Case 2: the next fetch proceeds normally and returns its data.
  - Case 3: if_flush coincident with mem_rsp_val. Required: if_rsp_val=0.
